// File: rtl/alu_pkg.sv
// Shared ALU sequencing package: default operand width and the state
// encoding used by the multi-cycle multiplier and divider.
package alu_pkg;

    // Default operand width for the multi-cycle arithmetic units.
    localparam int ALU_WIDTH = 32;

    // Sequencer states. FIX is only reached when the signed-multiply
    // build option is enabled; otherwise it is an unreachable encoding.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        SHIFT = 2'd2,
        FIX   = 2'd3
    } alu_state_e;

endpackage

// File: rtl/mul_seq.sv
// mul_seq: radix-2 shift-add multiplier, one multiplier bit per ADD/SHIFT
// pair, one operation in flight. Product is returned split across hi/lo.
//
// Handshake: mul_start is a request that is accepted only on an edge where
// the unit is in IDLE (the accepting edge). mul_busy is high from the
// accepting edge until the edge that raises mul_end. mul_end is a
// single-cycle pulse; hi/lo are final while it is high and hold until the
// next accepted start. Requests while busy are dropped, not queued.
//
// Build option MUL_SEQ_SIGNED_EN: adds the mul_signed input. Signed
// operations multiply magnitudes and fix the sign in an extra FIX cycle;
// every operation in that build takes 2*WIDTH+1 cycles. Without the macro
// the unit is unsigned only and takes 2*WIDTH cycles.
module mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    input  logic             mul_start,
`ifdef MUL_SEQ_SIGNED_EN
    input  logic             mul_signed,
`endif
    output logic             mul_busy,
    output logic             mul_end,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int IDX_W = $clog2(WIDTH) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    alu_state_e       state;
    logic [WIDTH-1:0] mcand;
    logic             carry;
    logic [IDX_W-1:0] idx;

`ifdef MUL_SEQ_SIGNED_EN
    logic             neg;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [2*WIDTH-1:0] prod_fixed;

    // Conditional two's-complement of a double-width value.
    function automatic logic [2*WIDTH-1:0] mul_abs(input logic [2*WIDTH-1:0] x,
                                                   input logic            neg_en);
        mul_abs = neg_en ? ((~x) + (2*WIDTH)'(1)) : x;
    endfunction

    // Operand magnitudes; -2^(WIDTH-1) maps to 2^(WIDTH-1) as an unsigned word.
    always_comb begin
        a_neg      = mul_signed & multiplicand[WIDTH-1];
        b_neg      = mul_signed & multiplier[WIDTH-1];
        a_mag      = a_neg ? ((~multiplicand) + WIDTH'(1)) : multiplicand;
        b_mag      = b_neg ? ((~multiplier) + WIDTH'(1)) : multiplier;
        prod_fixed = mul_abs({hi, lo}, neg);
    end
`endif

    // Sequencer and datapath: load in IDLE, conditional add, then shift right.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            mul_end  <= 1'b0;
            mul_busy <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            mcand    <= '0;
            carry    <= 1'b0;
            idx      <= '0;
`ifdef MUL_SEQ_SIGNED_EN
            neg      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    mul_end <= 1'b0;
                    if (mul_start) begin
`ifdef MUL_SEQ_SIGNED_EN
                        mcand <= a_mag;
                        lo    <= b_mag;
                        neg   <= a_neg ^ b_neg;
`else
                        mcand <= multiplicand;
                        lo    <= multiplier;
`endif
                        hi       <= '0;
                        carry    <= 1'b0;
                        idx      <= '0;
                        mul_busy <= 1'b1;
                        state    <= ADD;
                    end
                end

                ADD: begin
                    // Accumulate the multiplicand when the current multiplier bit is set.
                    if (lo[0]) begin
                        {carry, hi} <= {1'b0, hi} + {1'b0, mcand};
                    end
                    state <= SHIFT;
                end

                SHIFT: begin
                    // {carry,hi,lo} >> 1: consumed multiplier bit falls off the bottom.
                    carry <= 1'b0;
                    hi    <= {carry, hi[WIDTH-1:1]};
                    lo    <= {hi[0], lo[WIDTH-1:1]};
                    idx   <= idx + IDX_W'(1);
                    if (idx == LAST_IDX) begin
`ifdef MUL_SEQ_SIGNED_EN
                        state <= FIX;
`else
                        state    <= IDLE;
                        mul_end  <= 1'b1;
                        mul_busy <= 1'b0;
`endif
                    end else begin
                        state <= ADD;
                    end
                end

`ifdef MUL_SEQ_SIGNED_EN
                FIX: begin
                    // Apply the recorded sign to the full double-width product.
                    {hi, lo} <= prod_fixed;
                    mul_end  <= 1'b1;
                    mul_busy <= 1'b0;
                    state    <= IDLE;
                end
`endif

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
